gsim_mem_sched: RTL

Read scheduler and arbiter for the GSIM matrix-memory port. It shares the single 256-bit read interface (rreq/rrdy/dout/dout_vld) between two internal requesters: port 0, the coefficient-row fetch, and port 1, the b-vector/next-matrix prefetch. It issues at most one request per cycle, honours `i_mem_rrdy` back-pressure, and tracks in-flight reads in an in-order tag FIFO so each returned beat is routed back to the requester that issued it. It sits between the GSIM core datapath and the top-level `o_mem_*`/`i_mem_*` pins.

---
 rtl/gsim_mem_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gsim_mem_sched.sv
// gsim_mem_sched: read scheduler / arbiter for the GSIM matrix-memory port.
// Two requesters share one issue slot; an in-order tag FIFO routes returns.
module gsim_mem_sched #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 256,
    parameter int TAG_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvld0,
    output logic              o_rvld1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_idle,
    output logic              o_err
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic                 r_slot_vld;
    logic [ADDR_W-1:0]    r_slot_addr;
    logic                 r_slot_tag;
    logic [CW-1:0]        r_cnt;
    logic [TAG_DEPTH-1:0] r_tags;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic                 r_rr;
    logic                 r_rvld0;
    logic                 r_rvld1;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_spur;
    logic [CW:0]          w_used;
    logic                 w_credit;
    logic                 w_load;
    logic                 w_pick1;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_head_tag;

    // Accept/pop qualification, credit and round-robin grant.
    always_comb begin
        w_accept   = r_slot_vld & i_mem_rrdy;
        w_pop      = i_mem_dout_vld & (r_cnt != '0);
        w_spur     = i_mem_dout_vld & (r_cnt == '0);
        w_used     = {1'b0, r_cnt} + (CW + 1)'(r_slot_vld);
        w_credit   = w_used < (CW + 1)'(TAG_DEPTH);
        w_load     = (~r_slot_vld | w_accept) & w_credit & i_rst_n;
        w_pick1    = i_req1 & (~i_req0 | r_rr);
        w_gnt1     = w_load & w_pick1;
        w_gnt0     = w_load & i_req0 & ~w_pick1;
        w_head_tag = r_tags[r_rptr];
    end

    // Issue slot: load on grant, clear on accept, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_vld  <= 1'b0;
            r_slot_addr <= '0;
            r_slot_tag  <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_slot_vld  <= 1'b1;
            r_slot_addr <= w_gnt1 ? i_addr1 : i_addr0;
            r_slot_tag  <= w_gnt1;
        end else if (w_accept) begin
            r_slot_vld  <= 1'b0;
        end
    end

    // Round-robin pointer: the port not just granted gets priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr <= 1'b0;
        end
    end

    // In-order tag FIFO and outstanding-read counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tags <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_tags[r_wptr] <= r_slot_tag;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_accept & ~w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (~w_accept & w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Return path: register data and steer the valid by the head tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvld0 <= 1'b0;
            r_rvld1 <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rvld0 <= w_pop & ~w_head_tag;
            r_rvld1 <= w_pop & w_head_tag;
            if (w_pop) begin
                r_rdata <= i_mem_dout;
            end
        end
    end

    // Sticky error on a returned beat with nothing outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_spur) begin
            r_err <= 1'b1;
        end
    end

    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;
    assign o_rvld0    = r_rvld0;
    assign o_rvld1    = r_rvld1;
    assign o_rdata    = r_rdata;
    assign o_mem_rreq = r_slot_vld;
    assign o_mem_addr = r_slot_addr;
    assign o_idle     = ~r_slot_vld & (r_cnt == '0);
    assign o_err      = r_err;

endmodule
